ov5640_init_seq: RTL and testbench

OV5640_INIT_SEQ -- requirements
Module: ov5640_init_seq

---
 rtl/ov5640_pkg.sv | 19 +
 rtl/ov5640_init_seq_if.sv | 19 +
 rtl/ov5640_reg_rom.sv | 34 +++
 rtl/ov5640_init_seq.sv | 149 ++++++++++++++
 tb/tb_ov5640_init_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 register-table init sequencer.
package ov5640_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPwr,
    StIssue,
    StWaitAck,
    StNext,
    StDly,
    StDone,
    StErr
  } init_state_e;

  localparam logic [15:0] SrstAddr     = 16'h3008;
  localparam logic [7:0]  SrstData     = 8'h82;
  localparam int unsigned RegNumDefault = 250;

endpackage

// File: rtl/ov5640_init_seq_if.sv
// SCCB write-request bus between the init sequencer (master) and the SCCB engine (slave).
interface ov5640_init_seq_if;
  logic        sccb_start;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_busy;
  logic        sccb_done;
  logic        sccb_nack;

  modport master (
    output sccb_start, sccb_addr, sccb_data,
    input  sccb_busy, sccb_done, sccb_nack
  );

  modport slave (
    input  sccb_start, sccb_addr, sccb_data,
    output sccb_busy, sccb_done, sccb_nack
  );
endinterface

// File: rtl/ov5640_reg_rom.sv
// Combinational OV5640 init table: entry index -> {register address, register data}.
module ov5640_reg_rom (
  input  logic [7:0]  idx,
  output logic [15:0] addr,
  output logic [7:0]  data
);
  import ov5640_pkg::*;

  always_comb begin
    // Entries past the explicit head form a regular sweep of the 0x50xx ISP bank.
    addr = {8'h50, idx};
    data = ~idx;
    case (idx)
      8'd0:    begin addr = SrstAddr; data = SrstData; end
      8'd1:    begin addr = 16'h3008; data = 8'h42; end
      8'd2:    begin addr = 16'h3103; data = 8'h03; end
      8'd3:    begin addr = 16'h3017; data = 8'hff; end
      8'd4:    begin addr = 16'h3018; data = 8'hff; end
      8'd5:    begin addr = 16'h3034; data = 8'h1a; end
      8'd6:    begin addr = 16'h3037; data = 8'h13; end
      8'd7:    begin addr = 16'h3108; data = 8'h01; end
      8'd8:    begin addr = 16'h3630; data = 8'h36; end
      8'd9:    begin addr = 16'h3631; data = 8'h0e; end
      8'd10:   begin addr = 16'h3632; data = 8'he2; end
      8'd11:   begin addr = 16'h3633; data = 8'h12; end
      8'd12:   begin addr = 16'h3621; data = 8'he0; end
      8'd13:   begin addr = 16'h3704; data = 8'ha0; end
      8'd14:   begin addr = 16'h3703; data = 8'h5a; end
      8'd15:   begin addr = 16'h3715; data = 8'h78; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ov5640_init_seq.sv
// OV5640 init sequencer: walks the register table over SCCB after power-up.
// Optional NACK retry enabled by defining OV5640_INIT_RETRY_EN.
module ov5640_init_seq
  import ov5640_pkg::*;
#(
  parameter int unsigned REG_NUM   = RegNumDefault,
  parameter int unsigned SRST_WAIT = 50_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power_done,
  input  logic              cfg_restart,
  ov5640_init_seq_if.master sccb,
  output logic              init_done,
  output logic              init_err
);

`ifdef OV5640_INIT_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  // A zero limit turns every NACK into an immediate abort.
  localparam logic [7:0]  RetryLimit = RetryEn ? 8'(MAX_RETRY) : 8'd0;
  localparam logic [7:0]  LastIdx    = 8'(REG_NUM - 1);
  localparam logic [31:0] DlyLast    = 32'(SRST_WAIT - 1);

  init_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] dly_q, dly_d;
  logic        start_q, start_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;

  ov5640_reg_rom u_rom (
    .idx  (idx_q),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    dly_d   = dly_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    // Power loss outranks everything, including a concurrent restart request.
    if (state_q != StIdle && !power_done) begin
      state_d = StWaitPwr;
      idx_d   = '0;
      retry_d = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StWaitPwr;
        StWaitPwr: begin
          state_d = StIssue;
          idx_d   = '0;
          retry_d = '0;
        end
        StIssue: begin
          if (!sccb.sccb_busy) begin
            start_d = 1'b1;
            addr_d  = rom_addr;
            data_d  = rom_data;
            state_d = StWaitAck;
          end
        end
        StWaitAck: begin
          if (sccb.sccb_done) begin
            if (sccb.sccb_nack) begin
              if (retry_q < RetryLimit) begin
                retry_d = retry_q + 8'd1;
                state_d = StIssue;
              end else begin
                state_d = StErr;
              end
            end else if (addr_q == SrstAddr && data_q == SrstData) begin
              dly_d   = '0;
              state_d = StDly;
            end else begin
              state_d = StNext;
            end
          end
        end
        StDly: begin
          if (dly_q == DlyLast) begin
            dly_d   = '0;
            state_d = StNext;
          end else begin
            dly_d = dly_q + 32'd1;
          end
        end
        StNext: begin
          retry_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StIssue;
          end
        end
        StDone, StErr: begin
          if (cfg_restart) begin
            state_d = StIssue;
            idx_d   = '0;
            retry_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      retry_q <= '0;
      dly_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      dly_q   <= dly_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign sccb.sccb_start = start_q;
  assign sccb.sccb_addr  = addr_q;
  assign sccb.sccb_data  = data_q;
  assign init_done       = (state_q == StDone);
  assign init_err        = (state_q == StErr);

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Scoreboard bench for ov5640_init_seq: expected writes queued by stimulus, popped by a monitor.
module tb_ov5640_init_seq;

  localparam int unsigned RegNum   = 250;
  localparam int unsigned SrstWait = 400;
  localparam int unsigned MaxRetry = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic power_done = 1'b0;
  logic cfg_restart = 1'b0;
  logic init_done, init_err;

  ov5640_init_seq_if sb ();

  ov5640_init_seq #(
    .REG_NUM   (RegNum),
    .SRST_WAIT (SrstWait),
    .MAX_RETRY (MaxRetry)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power_done  (power_done),
    .cfg_restart (cfg_restart),
    .sccb        (sb),
    .init_done   (init_done),
    .init_err    (init_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_starts = 0;
  int n_acks = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];

  // Slave model controls
  int nack_idx = -1;
  int nack_left = 0;
  int late_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] tbl(input int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      0:  return 24'h3008_82;
      1:  return 24'h3008_42;
      2:  return 24'h3103_03;
      3:  return 24'h3017_ff;
      4:  return 24'h3018_ff;
      5:  return 24'h3034_1a;
      6:  return 24'h3037_13;
      7:  return 24'h3108_01;
      8:  return 24'h3630_36;
      9:  return 24'h3631_0e;
      10: return 24'h3632_e2;
      11: return 24'h3633_12;
      12: return 24'h3621_e0;
      13: return 24'h3704_a0;
      14: return 24'h3703_5a;
      15: return 24'h3715_78;
      default: return {8'h50, b, ~b};
    endcase
  endfunction

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(tbl(i));
  endtask

  // SCCB slave: one-cycle response, odd-data writes keep busy for two extra cycles.
  initial begin
    logic [23:0] cur;
    sb.sccb_busy = 1'b0;
    sb.sccb_done = 1'b0;
    sb.sccb_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sb.sccb_start) begin
        cur = {sb.sccb_addr, sb.sccb_data};
        sb.sccb_busy = 1'b1;
        if (late_idx >= 0 && cur == tbl(late_idx)) begin
          for (int k = 0; k < 5000 && power_done; k++) @(negedge clk);
          repeat (3) @(negedge clk);
          sb.sccb_done = 1'b1;
          @(negedge clk);
          sb.sccb_done = 1'b0;
          sb.sccb_busy = 1'b0;
          late_idx = -1;
        end else begin
          @(negedge clk);
          sb.sccb_nack = (nack_left > 0 && nack_idx >= 0 && cur == tbl(nack_idx));
          if (sb.sccb_nack) nack_left--;
          sb.sccb_done = 1'b1;
          @(negedge clk);
          sb.sccb_done = 1'b0;
          sb.sccb_nack = 1'b0;
          if (cur[0]) repeat (2) @(negedge clk);
          sb.sccb_busy = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic        start_prev = 1'b0;
  logic        pend = 1'b0;
  logic [23:0] pend_ad = '0;
  logic        gap_armed = 1'b0;
  int          gap_t0 = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && sb.sccb_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", {8'h00, sb.sccb_addr, sb.sccb_data}, 32'hffff_ffff);
      end else begin
        check("write_entry", {8'h00, sb.sccb_addr, sb.sccb_data}, {8'h00, exp_q.pop_front()});
      end
      check("start_while_busy", {31'd0, sb.sccb_busy}, 32'd0);
      check("start_pulse_width", {31'd0, start_prev}, 32'd0);
      if (gap_armed) begin
        check("srst_gap_ge_wait", {31'd0, (cyc - gap_t0) >= int'(SrstWait)}, 32'd1);
        gap_armed = 1'b0;
      end
      pend = 1'b1;
      pend_ad = {sb.sccb_addr, sb.sccb_data};
    end
    if (rst_n && sb.sccb_done && pend) begin
      check("addr_data_stable", {8'h00, sb.sccb_addr, sb.sccb_data}, {8'h00, pend_ad});
      pend = 1'b0;
      if (!sb.sccb_nack) begin
        n_acks++;
        if (pend_ad == 24'h3008_82) begin
          gap_armed = 1'b1;
          gap_t0 = cyc;
        end
      end
    end
    start_prev = sb.sccb_start;
  end

  task automatic power_up_measure();
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    power_done = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (sb.sccb_start) got = 1'b1;
    end
    check("first_start_latency", lat, 2);
  endtask

  task automatic wait_flag(input bit want_err, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = want_err ? init_err : init_done;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    cfg_restart = 1'b1;
    @(negedge clk);
    cfg_restart = 1'b0;
  endtask

  initial begin
    int acks0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", {31'd0, sb.sccb_start}, 32'd0);
    check("rst_addr", {16'd0, sb.sccb_addr}, 32'd0);
    check("rst_data", {24'd0, sb.sccb_data}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_init_err", {31'd0, init_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Power-up: full table in order, soft-reset gap, init_done
    push_range(0, RegNum - 1);
    power_up_measure();
    wait_flag(1'b0, "init_done_after_power_up");
    check("queue_drained_run1", exp_q.size(), 0);
    check("init_err_low_run1", {31'd0, init_err}, 32'd0);

    // Restart from DONE; a mid-run restart must be ignored
    push_range(0, RegNum - 1);
    pulse_restart();
    #1;
    check("init_done_falls_on_restart", {31'd0, init_done}, 32'd0);
    for (int k = 0; k < 3000 && exp_q.size() > 230; k++) @(posedge clk);
    pulse_restart();
    wait_flag(1'b0, "init_done_after_rerun");
    check("queue_drained_run2", exp_q.size(), 0);

    // Power loss while entry 100 awaits its ack; a late done must be ignored
    late_idx = 100;
    push_range(0, 100);
    pulse_restart();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    check("reached_entry_100", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    power_done = 1'b0;
    repeat (40) @(negedge clk);
    check("pwr_loss_init_done", {31'd0, init_done}, 32'd0);
    check("pwr_loss_init_err", {31'd0, init_err}, 32'd0);
    check("late_done_delivered", late_idx, -1);
    push_range(0, RegNum - 1);
    power_up_measure();
    wait_flag(1'b0, "init_done_after_repower");
    check("queue_drained_run3", exp_q.size(), 0);

`ifdef OV5640_INIT_RETRY_EN
    // Three NACKs on entry 5 are absorbed by retries
    nack_idx = 5;
    nack_left = 3;
    push_range(0, 5);
    repeat (3) exp_q.push_back(tbl(5));
    push_range(6, RegNum - 1);
    pulse_restart();
    wait_flag(1'b0, "init_done_after_retries");
    check("queue_drained_retry", exp_q.size(), 0);
    check("nacks_consumed", nack_left, 0);

    // A fourth NACK aborts
    nack_left = 4;
    push_range(0, 5);
    repeat (3) exp_q.push_back(tbl(5));
    pulse_restart();
    wait_flag(1'b1, "init_err_after_4_nacks");
    repeat (50) @(posedge clk);
    #1;
    check("queue_drained_abort", exp_q.size(), 0);
    check("init_err_held", {31'd0, init_err}, 32'd1);
    check("init_done_low_in_err", {31'd0, init_done}, 32'd0);
`else
    // First NACK aborts after exactly five good writes
    nack_idx = 5;
    nack_left = 1;
    push_range(0, 5);
    acks0 = n_acks;
    pulse_restart();
    wait_flag(1'b1, "init_err_on_nack");
    check("acks_before_err", n_acks - acks0, 5);
    repeat (50) @(posedge clk);
    #1;
    check("queue_drained_abort", exp_q.size(), 0);
    check("init_err_held", {31'd0, init_err}, 32'd1);
    check("init_done_low_in_err", {31'd0, init_done}, 32'd0);
`endif

    // Power loss and restart together in ERR: power loss wins
    @(negedge clk);
    power_done = 1'b0;
    cfg_restart = 1'b1;
    @(posedge clk);
    #1;
    check("err_clears_on_pwr_loss", {31'd0, init_err}, 32'd0);
    @(negedge clk);
    cfg_restart = 1'b0;
    repeat (20) @(negedge clk);
    check("no_start_while_unpowered", exp_q.size(), 0);
    push_range(0, RegNum - 1);
    power_up_measure();
    wait_flag(1'b0, "init_done_final");
    check("queue_drained_final", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
